// File: rtl/gmii_frame_checker_if.sv
// GMII receive-side signal bundle: one byte per clock with its data-valid and
// receive-error qualifiers. The PHY (or a bench standing in for it) drives it
// through the master modport; the frame checker samples it through the slave
// modport.
interface gmii_frame_checker_if;

   logic [7:0] gmii_rxd;
   logic       gmii_rx_dv;
   logic       gmii_rx_er;

   modport master (
      output gmii_rxd,
      output gmii_rx_dv,
      output gmii_rx_er
   );

   modport slave (
      input gmii_rxd,
      input gmii_rx_dv,
      input gmii_rx_er
   );

endinterface

// File: rtl/gmii_frame_checker.sv
// GMII receive frame checker.
// Follows the preamble/SFD, runs a CRC-32 over DA..FCS, and counts the bytes.
// When data-valid drops, each frame is classified as good, FCS error,
// length error, or rx_er/framing error. A result pulse and the frame length
// are presented, and one of four 64-bit statistics counters is bumped.
// The FCS is checked with the residue method: after the FCS bytes have been
// folded into the register, a clean frame always leaves the constant
// 0xDEBB20E3 behind. This means the FCS bytes never have to be buffered.
module gmii_frame_checker #(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518
) (
   input  logic                  aclk,
   input  logic                  arstn,
   gmii_frame_checker_if.slave   gmii,
   input  logic                  clear,
   output logic                  frame_done,
   output logic [1:0]            frame_status,
   output logic [15:0]           frame_len,
   output logic [63:0]           cnt_good,
   output logic [63:0]           cnt_fcs_err,
   output logic [63:0]           cnt_len_err,
   output logic [63:0]           cnt_rx_err
);

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
   localparam logic [15:0] LEN_MAX_COUNT = 16'hFFFF;
   localparam logic [15:0] MIN_LEN       = 16'(MIN_FRAME);
   localparam logic [15:0] MAX_LEN       = 16'(MAX_FRAME);

   localparam logic [1:0] ST_GOOD    = 2'd0;
   localparam logic [1:0] ST_FCS_ERR = 2'd1;
   localparam logic [1:0] ST_LEN_ERR = 2'd2;
   localparam logic [1:0] ST_RX_ERR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } state_t;

   state_t      state_q,  state_d;
   logic [31:0] crc_q,    crc_d;
   logic [15:0] len_q,    len_d;
   logic        err_q,    err_d;
   logic        done_q,   done_d;
   logic [1:0]  status_q, status_d;
   logic [15:0] flen_q,   flen_d;

   logic [63:0] cntGood_q;
   logic [63:0] cntFcs_q;
   logic [63:0] cntLen_q;
   logic [63:0] cntRx_q;

   // One byte of the reflected CRC-32, processed least significant bit first.
   function automatic logic [31:0] crcByte(input logic [31:0] crcIn,
                                           input logic [7:0]  data);
      logic [31:0] c;
      c = crcIn;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) begin
            c = (c >> 1) ^ CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   // Priority classification: line errors trump length, length trumps FCS.
   function automatic logic [1:0] classify(input logic        errFlag,
                                           input logic [15:0] len,
                                           input logic [31:0] crc);
      if (errFlag) begin
         return ST_RX_ERR;
      end else if ((len < MIN_LEN) || (len > MAX_LEN)) begin
         return ST_LEN_ERR;
      end else if (crc != CRC_RESIDUE) begin
         return ST_FCS_ERR;
      end else begin
         return ST_GOOD;
      end
   endfunction

   // Next-state logic: frame tracking, CRC/length accumulation, classification.
   always_comb begin
      state_d  = state_q;
      crc_d    = crc_q;
      len_d    = len_q;
      err_d    = err_q;
      done_d   = 1'b0;
      status_d = status_q;
      flen_d   = flen_q;

      unique case (state_q)
         IDLE: begin
            if (gmii.gmii_rx_dv) begin
               if (gmii.gmii_rxd == PREAMBLE_BYTE) begin
                  state_d = PREAMBLE;
               end else if (gmii.gmii_rxd == SFD_BYTE) begin
                  state_d = DATA;
                  crc_d   = CRC_INIT;
                  len_d   = '0;
                  err_d   = 1'b0;
               end else begin
                  state_d = DROP;
               end
            end
         end

         PREAMBLE: begin
            if (!gmii.gmii_rx_dv) begin
               state_d = IDLE;
            end else if (gmii.gmii_rx_er) begin
               state_d = DROP;
            end else if (gmii.gmii_rxd == PREAMBLE_BYTE) begin
               state_d = PREAMBLE;
            end else if (gmii.gmii_rxd == SFD_BYTE) begin
               state_d = DATA;
               crc_d   = CRC_INIT;
               len_d   = '0;
               err_d   = 1'b0;
            end else begin
               state_d = DROP;
            end
         end

         DATA: begin
            if (gmii.gmii_rx_dv) begin
               crc_d = crcByte(crc_q, gmii.gmii_rxd);
               if (len_q != LEN_MAX_COUNT) begin
                  len_d = len_q + 16'd1;
               end
               if (gmii.gmii_rx_er) begin
                  err_d = 1'b1;
               end
            end else begin
               done_d   = 1'b1;
               status_d = classify(err_q, len_q, crc_q);
               flen_d   = len_q;
               state_d  = IDLE;
            end
         end

         DROP: begin
            if (!gmii.gmii_rx_dv) begin
               done_d   = 1'b1;
               status_d = ST_RX_ERR;
               flen_d   = '0;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and registered frame result; an abandoned frame dies with the reset.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_q  <= IDLE;
         crc_q    <= CRC_INIT;
         len_q    <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         status_q <= ST_GOOD;
         flen_q   <= '0;
      end else begin
         state_q  <= state_d;
         crc_q    <= crc_d;
         len_q    <= len_d;
         err_q    <= err_d;
         done_q   <= done_d;
         status_q <= status_d;
         flen_q   <= flen_d;
      end
   end

   // Statistics counters; clear takes precedence over a coincident increment.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         cntGood_q <= '0;
         cntFcs_q  <= '0;
         cntLen_q  <= '0;
         cntRx_q   <= '0;
      end else if (clear) begin
         cntGood_q <= '0;
         cntFcs_q  <= '0;
         cntLen_q  <= '0;
         cntRx_q   <= '0;
      end else if (done_d) begin
         unique case (status_d)
            ST_GOOD:    cntGood_q <= cntGood_q + 64'd1;
            ST_FCS_ERR: cntFcs_q  <= cntFcs_q  + 64'd1;
            ST_LEN_ERR: cntLen_q  <= cntLen_q  + 64'd1;
            default:    cntRx_q   <= cntRx_q   + 64'd1;
         endcase
      end
   end

   assign frame_done   = done_q;
   assign frame_status = status_q;
   assign frame_len    = flen_q;
   assign cnt_good     = cntGood_q;
   assign cnt_fcs_err  = cntFcs_q;
   assign cnt_len_err  = cntLen_q;
   assign cnt_rx_err   = cntRx_q;

endmodule

// File: tb/tb_gmii_frame_checker.sv
// Testbench for gmii_frame_checker: directed frames plus a randomized mix.
// Expected results come from a frame-level reference model. That model
// computes the standard Ethernet FCS over the payload, compares it to the
// trailing four bytes, and applies the length and rx_er rules to the byte
// list as a whole.
module tb_gmii_frame_checker;

   localparam int MIN_FRAME = 64;
   localparam int MAX_FRAME = 1518;

   logic        aclk  = 1'b0;
   logic        arstn = 1'b1;
   logic        clear = 1'b0;
   logic        frame_done;
   logic [1:0]  frame_status;
   logic [15:0] frame_len;
   logic [63:0] cnt_good;
   logic [63:0] cnt_fcs_err;
   logic [63:0] cnt_len_err;
   logic [63:0] cnt_rx_err;

   gmii_frame_checker_if gmiiBus ();

   gmii_frame_checker #(
      .MIN_FRAME (MIN_FRAME),
      .MAX_FRAME (MAX_FRAME)
   ) dut (
      .aclk         (aclk),
      .arstn        (arstn),
      .gmii         (gmiiBus),
      .clear        (clear),
      .frame_done   (frame_done),
      .frame_status (frame_status),
      .frame_len    (frame_len),
      .cnt_good     (cnt_good),
      .cnt_fcs_err  (cnt_fcs_err),
      .cnt_len_err  (cnt_len_err),
      .cnt_rx_err   (cnt_rx_err)
   );

   // 100 MHz-style free-running clock
   always #5 aclk = ~aclk;

   int checkCount = 0;
   int passCount  = 0;
   int pulseCount = 0;

   logic [7:0]  frameBytes[$];
   logic [1:0]  expStatusQ[$];
   logic [15:0] expLenQ[$];

   logic [63:0] modelGood = '0;
   logic [63:0] modelFcs  = '0;
   logic [63:0] modelLen  = '0;
   logic [63:0] modelRx   = '0;
   logic [1:0]  lastStatus = '0;
   logic [15:0] lastLen    = '0;
   logic        prevDone   = 1'b0;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one GMII cycle; inputs change on the falling edge
   task automatic applyStimulus(input logic dv, input logic [7:0] d, input logic er);
      @(negedge aclk);
      gmiiBus.gmii_rx_dv = dv;
      gmiiBus.gmii_rxd   = d;
      gmiiBus.gmii_rx_er = er;
      clear              = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
   endtask

   task automatic zeroModel();
      modelGood = '0;
      modelFcs  = '0;
      modelLen  = '0;
      modelRx   = '0;
   endtask

   // Closing dv=0 cycle: register the expected result and update the counter model
   task automatic endFrame(input logic [1:0] st, input logic [15:0] ln, input logic doClear);
      @(negedge aclk);
      gmiiBus.gmii_rx_dv = 1'b0;
      gmiiBus.gmii_rxd   = 8'h00;
      gmiiBus.gmii_rx_er = 1'b0;
      clear              = doClear;
      expStatusQ.push_back(st);
      expLenQ.push_back(ln);
      lastStatus = st;
      lastLen    = ln;
      if (doClear) begin
         zeroModel();
      end else begin
         case (st)
            2'd0:    modelGood++;
            2'd1:    modelFcs++;
            2'd2:    modelLen++;
            default: modelRx++;
         endcase
      end
   endtask

   task automatic sendFrame(input int preLen, input int erIdx, input logic [1:0] st,
                            input logic [15:0] ln, input logic doClear);
      for (int i = 0; i < preLen; i++) applyStimulus(1'b1, 8'h55, 1'b0);
      applyStimulus(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < frameBytes.size(); i++)
         applyStimulus(1'b1, frameBytes[i], (i == erIdx));
      endFrame(st, ln, doClear);
   endtask

   // Standard Ethernet FCS over the first n bytes (complemented CRC-32)
   function automatic logic [31:0] refFcs(input int n);
      logic [31:0] crc;
      crc = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         crc = crc ^ {24'h0, frameBytes[i]};
         for (int b = 0; b < 8; b++)
            crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
      end
      return ~crc;
   endfunction

   function automatic logic [1:0] modelStatus(input int erIdx);
      int          n;
      logic [31:0] rxFcs;
      n = frameBytes.size();
      if (erIdx >= 0 && erIdx < n) return 2'd3;
      if (n < MIN_FRAME || n > MAX_FRAME) return 2'd2;
      rxFcs = {frameBytes[n-1], frameBytes[n-2], frameBytes[n-3], frameBytes[n-4]};
      return (rxFcs == refFcs(n - 4)) ? 2'd0 : 2'd1;
   endfunction

   task automatic appendFcs();
      logic [31:0] fcs;
      fcs = refFcs(frameBytes.size());
      frameBytes.push_back(fcs[7:0]);
      frameBytes.push_back(fcs[15:8]);
      frameBytes.push_back(fcs[23:16]);
      frameBytes.push_back(fcs[31:24]);
   endtask

   task automatic buildSpecGood();
      frameBytes.delete();
      for (int i = 1; i <= 60; i++) frameBytes.push_back(8'(i));
      frameBytes.push_back(8'h34);
      frameBytes.push_back(8'h4C);
      frameBytes.push_back(8'hA0);
      frameBytes.push_back(8'h62);
   endtask

   task automatic buildRandom(input int n, input logic withFcs);
      frameBytes.delete();
      for (int i = 0; i < n; i++) frameBytes.push_back(8'($urandom));
      if (withFcs) appendFcs();
   endtask

   task automatic waitDrain();
      int t;
      t = 0;
      while (expStatusQ.size() != 0 && t < 50) begin
         @(negedge aclk);
         t++;
      end
      checkOutput("drain_pending", 64'(expStatusQ.size()), 64'd0);
      idleCycles(2);
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_cnt_good"},    cnt_good,     modelGood);
      checkOutput({tag, "_cnt_fcs"},     cnt_fcs_err,  modelFcs);
      checkOutput({tag, "_cnt_len"},     cnt_len_err,  modelLen);
      checkOutput({tag, "_cnt_rx"},      cnt_rx_err,   modelRx);
      checkOutput({tag, "_status_hold"}, frame_status, lastStatus);
      checkOutput({tag, "_len_hold"},    frame_len,    lastLen);
   endtask

   // Scoreboard: every result pulse must match the oldest expected frame
   always @(negedge aclk) begin
      if (frame_done) begin
         pulseCount++;
         checkOutput("done_width", prevDone, 1'b0);
         if (expStatusQ.size() == 0) begin
            checkOutput("unexpected_done", 1'b1, 1'b0);
         end else begin
            checkOutput("frame_status", frame_status, expStatusQ.pop_front());
            checkOutput("frame_len", frame_len, expLenQ.pop_front());
         end
      end
      prevDone = frame_done;
   end

   initial begin
      int pulsesBefore;
      int kind, n, idx, pre;
      logic [1:0] st;

      gmiiBus.gmii_rx_dv = 1'b0;
      gmiiBus.gmii_rxd   = 8'h00;
      gmiiBus.gmii_rx_er = 1'b0;
      #2 arstn = 1'b0;
      repeat (3) @(negedge aclk);
      checkOutput("reset_done", frame_done, 1'b0);
      checkCounters("reset");
      arstn = 1'b1;
      idleCycles(2);

      $display("[TB] directed good frame");
      buildSpecGood();
      sendFrame(7, -1, 2'd0, 16'd64, 1'b0);
      waitDrain();
      checkCounters("good");

      $display("[TB] fcs, short and long frames");
      buildSpecGood();
      frameBytes[15] = 8'h11;
      sendFrame(7, -1, 2'd1, 16'd64, 1'b0);
      buildRandom(20, 1'b0);
      sendFrame(7, -1, 2'd2, 16'd20, 1'b0);
      buildRandom(1515, 1'b1);
      sendFrame(7, -1, 2'd2, 16'd1519, 1'b0);
      waitDrain();
      checkCounters("lenerr");

      $display("[TB] rx_er and framing drop");
      buildSpecGood();
      sendFrame(7, 30, 2'd3, 16'd64, 1'b0);
      applyStimulus(1'b1, 8'h55, 1'b0);
      applyStimulus(1'b1, 8'h12, 1'b0);
      applyStimulus(1'b1, 8'hD5, 1'b0);
      applyStimulus(1'b1, 8'hAB, 1'b0);
      endFrame(2'd3, 16'd0, 1'b0);
      waitDrain();
      checkCounters("rxerr");

      $display("[TB] back-to-back frames and clear");
      @(negedge aclk);
      clear = 1'b1;
      zeroModel();
      idleCycles(2);
      checkCounters("clear");
      pulsesBefore = pulseCount;
      for (int f = 0; f < 10; f++) begin
         buildRandom(60 + int'($urandom_range(0, 20)), 1'b1);
         sendFrame(7, -1, 2'd0, 16'(frameBytes.size()), 1'b0);
      end
      waitDrain();
      checkOutput("b2b_pulses", 64'(pulseCount - pulsesBefore), 64'd10);
      checkCounters("b2b");
      pulsesBefore = pulseCount;
      for (int f = 0; f < 10; f++) begin
         buildRandom(60 + int'($urandom_range(0, 20)), 1'b1);
         sendFrame(7, -1, 2'd0, 16'(frameBytes.size()), (f == 9));
      end
      waitDrain();
      checkOutput("b2b_clear_pulses", 64'(pulseCount - pulsesBefore), 64'd10);
      checkCounters("b2b_clear");

      $display("[TB] reset during a frame");
      buildSpecGood();
      pulsesBefore = pulseCount;
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h55, 1'b0);
      applyStimulus(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < 30; i++) applyStimulus(1'b1, frameBytes[i], 1'b0);
      @(negedge aclk);
      arstn = 1'b0;
      gmiiBus.gmii_rx_dv = 1'b0;
      zeroModel();
      lastStatus = 2'd0;
      lastLen    = 16'd0;
      @(negedge aclk);
      checkCounters("inreset");
      arstn = 1'b1;
      idleCycles(2);
      sendFrame(7, -1, 2'd0, 16'd64, 1'b0);
      waitDrain();
      checkOutput("abort_pulses", 64'(pulseCount - pulsesBefore), 64'd1);
      checkCounters("after_reset");

      $display("[TB] randomized frames");
      for (int f = 0; f < 40; f++) begin
         kind = int'($urandom_range(0, 9));
         pre  = int'($urandom_range(0, 7));
         idx  = -1;
         if (kind == 9) begin
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
               applyStimulus(1'b1, 8'h55, 1'b0);
            applyStimulus(1'b1, 8'h20 + 8'($urandom_range(0, 15)), 1'b0);
            for (int i = 0; i < int'($urandom_range(0, 20)); i++)
               applyStimulus(1'b1, 8'($urandom), 1'b0);
            endFrame(2'd3, 16'd0, 1'b0);
         end else begin
            if (kind <= 4) begin
               buildRandom(int'($urandom_range(60, 200)), 1'b1);
            end else if (kind == 5) begin
               buildRandom(int'($urandom_range(60, 200)), 1'b1);
               n = int'($urandom_range(0, frameBytes.size() - 1));
               frameBytes[n] = frameBytes[n] ^ (8'h01 << $urandom_range(0, 7));
            end else if (kind == 6) begin
               buildRandom(int'($urandom_range(1, 63)), 1'b0);
            end else if (kind == 7) begin
               buildRandom(int'($urandom_range(1515, 1526)), 1'b1);
            end else begin
               buildRandom(int'($urandom_range(60, 200)), 1'b1);
               idx = int'($urandom_range(0, frameBytes.size() - 1));
            end
            st = modelStatus(idx);
            sendFrame(pre, idx, st, 16'(frameBytes.size()), 1'b0);
         end
         idleCycles(int'($urandom_range(0, 2)));
      end
      waitDrain();
      checkCounters("random");

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/gmii_frame_checker.md
GMII_FRAME_CHECKER -- requirements
Module: gmii_frame_checker

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 64, minimum legal frame length in bytes (DA through FCS).
REQ-002 SHALL have parameter MAX_FRAME, default 1518, maximum legal frame length in bytes (DA through FCS).
REQ-003 SHALL have port aclk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port arstn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port gmii_rxd  in  8  receive data byte.
REQ-006 SHALL have port gmii_rx_dv  in  1  data valid.
REQ-007 SHALL have port gmii_rx_er  in  1  receive error.
REQ-008 SHALL have port clear  in  1  synchronous counter clear, level-sampled.
REQ-009 SHALL have port frame_done  out  1  one-cycle pulse: a frame was classified.
REQ-010 SHALL have port frame_status  out  2  result of that frame: 0 good, 1 FCS error, 2 length error, 3 rx_er/framing error.
REQ-011 SHALL have port frame_len  out  16  byte count of that frame.
REQ-012 SHALL have ports cnt_good, cnt_fcs_err, cnt_len_err, cnt_rx_err  out  64 each  frame counters.

Function
REQ-013 SHALL sample all inputs on each aclk rising edge; one GMII byte per cycle.
REQ-014 SHALL implement FSM states IDLE, PREAMBLE, DATA, DROP.
REQ-015 IDLE transitions:
  - dv=1 and rxd=0x55: go to PREAMBLE.
  - dv=1 and rxd=0xD5: go to DATA.
  - dv=1 with any other byte: go to DROP.
  - dv=0: stay in IDLE.
REQ-016 PREAMBLE transitions:
  - 0x55: stay.
  - 0xD5: go to DATA.
  - dv=1 with any other byte, or rx_er=1: go to DROP.
  - dv=0: go to IDLE; nothing is counted.
REQ-017 On entry to DATA, SHALL set CRC register to 0xFFFFFFFF, frame length to 0, and error flag to 0.
REQ-018 In DATA, for each cycle with dv=1:
  - update CRC with rxd, reflected polynomial 0xEDB88320, LSB first;
  - increment length, saturating at 0xFFFF;
  - set the error flag if rx_er=1.
REQ-019 When DATA samples dv=0, SHALL classify the frame in this priority order: error flag set gives 3; length <MIN_FRAME or >MAX_FRAME gives 2; CRC register ≠0xDEBB20E3 gives 1; otherwise 0. It SHALL then go to IDLE.
REQ-020 Classification SHALL register frame_done=1, frame_status and frame_len, and increment the matching counter, all on the same edge. frame_done SHALL be high in the cycle after the first dv=0 cycle.
REQ-021 frame_done SHALL be high for exactly one cycle. frame_status and frame_len SHALL hold until the next classification.
REQ-022 DROP SHALL ignore data until dv=0. It SHALL then pulse frame_done with status 3 and frame_len 0, increment cnt_rx_err, and go to IDLE.
REQ-023 Back-to-back frames separated by a single dv=0 cycle SHALL both be classified with no loss.
REQ-024 Counters SHALL be 64-bit and wrap modulo 2^64.
REQ-025 clear=1 SHALL zero all counters on that edge. If an increment coincides with clear, clear SHALL win and the increment is lost. clear SHALL NOT affect the FSM or the frame_* outputs.

Reset
REQ-026 When arstn=0, SHALL asynchronously force: FSM to IDLE, frame_done=0, frame_status=0, frame_len=0, all counters to 0, CRC register to 0xFFFFFFFF.
REQ-027 A frame in progress when reset asserts SHALL be discarded and not counted. After release, the first classified frame SHALL be the next one beginning in IDLE.

Verification
REQ-028 Good frame: preamble 7×0x55, SFD 0xD5, bytes 0x01..0x3C, FCS 0x34 0x4C 0xA0 0x62, then dv=0 -> frame_done pulse with status 0, frame_len 64, cnt_good=1.
REQ-029 Same frame with byte 0x10 changed to 0x11 -> status 1, frame_len 64, cnt_fcs_err=1. Then 20-byte frame -> status 2, frame_len 20. Then 1519-byte frame -> status 2, cnt_len_err=2.
REQ-030 Good frame with rx_er=1 on byte 30 -> status 3, cnt_rx_err=1. Frame starting with 0x55 followed by 0x12 -> DROP, status 3, frame_len 0, cnt_rx_err=2.
REQ-031 Ten good frames separated by one idle cycle each -> ten frame_done pulses, cnt_good=10. clear asserted on the edge of the tenth classification -> cnt_good=0.
REQ-032 arstn pulsed low mid-DATA of a good frame, then a good frame sent -> no pulse for the aborted frame, then one status-0 pulse, cnt_good=1.
